// File: rtl/uart_tx_arb_if.sv
// Bundles the requester byte-stream ports, the APB master port and the error
// flags of uart_tx_arb.
//   master : arbiter view (drives req_ready, grant, APB control/addr/wdata, err)
//   slave  : environment view (drives req_valid/last/data, APB rdata/ready/slverr, err_clr)
interface uart_tx_arb_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;

    logic               apbm_psel;
    logic               apbm_penable;
    logic               apbm_pwrite;
    logic [15:0]        apbm_paddr;
    logic [31:0]        apbm_pwdata;
    logic [31:0]        apbm_prdata;
    logic               apbm_pready;
    logic               apbm_pslverr;

    logic [1:0]         err;
    logic [1:0]         err_clr;

    modport master (
        input  req_valid, req_last, req_data,
        output req_ready, grant,
        output apbm_psel, apbm_penable, apbm_pwrite, apbm_paddr, apbm_pwdata,
        input  apbm_prdata, apbm_pready, apbm_pslverr,
        output err,
        input  err_clr
    );

    modport slave (
        output req_valid, req_last, req_data,
        input  req_ready, grant,
        input  apbm_psel, apbm_penable, apbm_pwrite, apbm_paddr, apbm_pwdata,
        output apbm_prdata, apbm_pready, apbm_pslverr,
        input  err,
        output err_clr
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-atomic arbiter that funnels N_REQ byte streams into one
// UART TX register over APB. Each byte: poll FSTAT until TX is not full, then
// write TX.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_tx_arb_if.master (requesters, APB master, err flags)
module uart_tx_arb #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned HOLD_TIMEOUT = 255,
    parameter logic [15:0] ADDR_FSTAT   = 16'h0008,
    parameter logic [15:0] ADDR_TX      = 16'h000c,
    parameter int unsigned TXFULL_BIT   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_arb_if.master bus
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(HOLD_TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_POLL_S, S_POLL_A, S_WR_S, S_WR_A
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [1:0]       err_q, err_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [15:0]      paddr_q, paddr_d;
    logic [31:0]      pwdata_q, pwdata_d;

    logic             cand_found;
    logic [IW-1:0]    cand_idx;
    logic             accept;
    logic [IW-1:0]    accept_idx;
    logic             timeout_hit;
    logic             complete;
    logic [1:0]       err_set;

    // Round-robin candidate: first valid requester after ptr
    always_comb begin
        int unsigned idx;
        idx        = 0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!cand_found && bus.req_valid[idx]) begin
                cand_found = 1'b1;
                cand_idx   = IW'(idx);
            end
        end
    end

    // Byte acceptance: any candidate in IDLE, only the owner in HOLD
    always_comb begin
        accept     = 1'b0;
        accept_idx = owner_q;
        case (state_q)
            S_IDLE: begin
                accept     = cand_found;
                accept_idx = cand_idx;
            end
            S_HOLD:  accept = bus.req_valid[owner_q];
            default: ;
        endcase
    end

    assign bus.req_ready = accept ? (N_REQ'(1) << accept_idx) : '0;

    // Stall count reaches the limit in this idle HOLD cycle
    assign timeout_hit = (HOLD_TIMEOUT != 0) && (tcnt_q == TW'(HOLD_TIMEOUT - 1));

    // Byte finished: slave error on poll drops it, or TX write completed
    assign complete = bus.apbm_pready &&
                      (((state_q == S_POLL_A) && bus.apbm_pslverr) || (state_q == S_WR_A));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cand_found) state_d = S_POLL_S;
            end
            S_HOLD: begin
                if (accept)           state_d = S_POLL_S;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_POLL_S: state_d = S_POLL_A;
            S_POLL_A: begin
                if (bus.apbm_pready) begin
                    if (bus.apbm_pslverr)                  state_d = last_q ? S_IDLE : S_HOLD;
                    else if (bus.apbm_prdata[TXFULL_BIT])  state_d = S_POLL_S;
                    else                                   state_d = S_WR_S;
                end
            end
            S_WR_S: state_d = S_WR_A;
            S_WR_A: begin
                if (bus.apbm_pready) state_d = last_q ? S_IDLE : S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic; APB outputs are registered from the next state
    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        data_d    = data_q;
        last_d    = last_q;
        tcnt_d    = tcnt_q;
        err_set   = 2'b00;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;

        if (accept) begin
            owner_d = accept_idx;
            grant_d = N_REQ'(1) << accept_idx;
            data_d  = bus.req_data[8*32'(accept_idx) +: 8];
            last_d  = bus.req_last[accept_idx];
            tcnt_d  = '0;
        end

        if ((state_q == S_HOLD) && !accept) begin
            if (timeout_hit) begin
                err_set[1] = 1'b1;
                tcnt_d     = '0;
                grant_d    = '0;
                ptr_d      = owner_q;
            end else if (HOLD_TIMEOUT != 0) begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end

        if (bus.apbm_pready && bus.apbm_pslverr &&
            ((state_q == S_POLL_A) || (state_q == S_WR_A))) begin
            err_set[0] = 1'b1;
        end

        if (complete && last_q) begin
            grant_d = '0;
            ptr_d   = owner_q;
        end

        // Set wins over a coincident clear
        err_d = (err_q & ~bus.err_clr) | err_set;

        case (state_d)
            S_POLL_S: begin
                psel_d  = 1'b1;
                paddr_d = ADDR_FSTAT;
            end
            S_POLL_A: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                paddr_d   = ADDR_FSTAT;
            end
            S_WR_S: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = ADDR_TX;
                pwdata_d = {24'h0, data_q};
            end
            S_WR_A: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                pwrite_d  = 1'b1;
                paddr_d   = ADDR_TX;
                pwdata_d  = {24'h0, data_q};
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= IW'(N_REQ - 1);
            owner_q   <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            tcnt_q    <= '0;
            err_q     <= 2'b00;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            last_q    <= last_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.err          = err_q;
    assign bus.apbm_psel    = psel_q;
    assign bus.apbm_penable = penable_q;
    assign bus.apbm_pwrite  = pwrite_q;
    assign bus.apbm_paddr   = paddr_q;
    assign bus.apbm_pwdata  = pwdata_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed packets push expected TX writes
// into a queue; a negedge monitor pops and compares on every completed write.
module tb_uart_tx_arb;
    localparam int unsigned N       = 4;
    localparam logic [15:0] A_FSTAT = 16'h0008;
    localparam logic [15:0] A_TX    = 16'h000c;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.N_REQ(N)) bus ();

    uart_tx_arb #(
        .N_REQ(N), .HOLD_TIMEOUT(4), .ADDR_FSTAT(A_FSTAT), .ADDR_TX(A_TX), .TXFULL_BIT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] rq [N][$];
    int         exp_id [$];
    logic [7:0] exp_d  [$];

    int rdy_cnt [N];
    int gcnt    [N];
    int poll_cnt;

    int   full_left  = 0;
    logic slverr_arm = 1'b0;

    assign bus.apbm_pready  = 1'b1;
    assign bus.apbm_prdata  = (full_left > 0) ? 32'h0000_0100 : 32'h0;
    assign bus.apbm_pslverr = slverr_arm & bus.apbm_psel & bus.apbm_penable & bus.apbm_pwrite;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input int id, input bit last, input logic [7:0] d, input bit expect_wr);
        rq[id].push_back({last, d});
        if (expect_wr) begin
            exp_id.push_back(id);
            exp_d.push_back(d);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            rdy_cnt[i] = 0;
            gcnt[i]    = 0;
        end
        poll_cnt = 0;
    endtask

    function automatic bit rq_busy();
        bit b = 1'b0;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_d.size() != 0 || bus.grant != '0 || rq_busy()) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: not drained within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] mask, input int budget);
        int n = 0;
        while (bus.grant != mask && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: grant %b never reached %b", name, bus.grant, mask);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Requester driver: pop accepted bytes, present queue heads
    logic [N-1:0] acc_drv;
    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            acc_drv = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc_drv[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    bus.req_valid[i]      = 1'b1;
                    bus.req_last[i]       = rq[i][0][8];
                    bus.req_data[8*i +: 8] = rq[i][0][7:0];
                end else begin
                    bus.req_valid[i]      = 1'b0;
                    bus.req_last[i]       = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // APB slave side effects: consume FULL responses, disarm slverr after one write
    logic poll_done_s, wr_done_s;
    initial begin
        forever begin
            @(negedge clk);
            poll_done_s = bus.apbm_psel & bus.apbm_penable & ~bus.apbm_pwrite & bus.apbm_pready;
            wr_done_s   = bus.apbm_psel & bus.apbm_penable &  bus.apbm_pwrite & bus.apbm_pready;
            @(posedge clk); #1;
            if (poll_done_s && full_left > 0) full_left--;
            if (wr_done_s) slverr_arm = 1'b0;
        end
    end

    // Monitor / scoreboard
    initial begin
        int         id;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (($countones(bus.req_ready) > 1) || ((bus.req_ready & ~bus.req_valid) != '0) ||
                    ((bus.grant != '0) && ((bus.req_ready & ~bus.grant) != '0))) begin
                    errors++;
                    $display("FAIL ready_legal: ready=%b valid=%b grant=%b at %0t",
                             bus.req_ready, bus.req_valid, bus.grant, $time);
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.req_ready[i] && bus.req_valid[i]) rdy_cnt[i]++;
                    if (bus.grant[i]) gcnt[i]++;
                end
                if (bus.apbm_psel && bus.apbm_penable && !bus.apbm_pwrite && bus.apbm_pready) begin
                    poll_cnt++;
                    chk("poll_addr", 32'(bus.apbm_paddr), 32'(A_FSTAT));
                end
                if (bus.apbm_psel && bus.apbm_penable && bus.apbm_pwrite && bus.apbm_pready) begin
                    if (exp_d.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: data %h at %0t", bus.apbm_pwdata, $time);
                    end else begin
                        id = exp_id.pop_front();
                        d  = exp_d.pop_front();
                        chk("wr_owner", 32'(bus.grant), 32'(1) << id);
                        chk("wr_data", bus.apbm_pwdata, {24'h0, d});
                        chk("wr_addr", 32'(bus.apbm_paddr), 32'(A_TX));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.err_clr = 2'b00;
        clear_counts();
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_grant",   32'(bus.grant), 0);
        chk("rst_ready",   32'(bus.req_ready), 0);
        chk("rst_err",     32'(bus.err), 0);
        chk("rst_psel",    32'(bus.apbm_psel), 0);
        chk("rst_penable", 32'(bus.apbm_penable), 0);
        chk("rst_pwrite",  32'(bus.apbm_pwrite), 0);
        chk("rst_paddr",   32'(bus.apbm_paddr), 0);
        chk("rst_pwdata",  bus.apbm_pwdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte
        clear_counts();
        push(0, 1'b1, 8'h41, 1'b1);
        wait_done("t1_drain", 50);
        chk("t1_ready0_pulses", 32'(rdy_cnt[0]), 1);
        chk("t1_grant0_cycles", 32'(gcnt[0]), 4);
        chk("t1_polls", 32'(poll_cnt), 1);

        // TX FIFO full three times
        clear_counts();
        full_left = 3;
        push(0, 1'b1, 8'h5a, 1'b1);
        wait_done("t2_drain", 80);
        chk("t2_polls", 32'(poll_cnt), 4);
        chk("t2_ready0_pulses", 32'(rdy_cnt[0]), 1);
        chk("t2_grant0_cycles", 32'(gcnt[0]), 10);

        // Round-robin packets, all valid from reset
        do_reset();
        clear_counts();
        push(0, 1'b0, 8'h10, 1'b1); push(0, 1'b0, 8'h11, 1'b1); push(0, 1'b1, 8'h12, 1'b1);
        push(1, 1'b0, 8'h20, 1'b1); push(1, 1'b0, 8'h21, 1'b1); push(1, 1'b1, 8'h22, 1'b1);
        push(2, 1'b0, 8'h30, 1'b1); push(2, 1'b0, 8'h31, 1'b1); push(2, 1'b1, 8'h32, 1'b1);
        wait_grant("t3_grant2", 4'b0100, 200);
        push(0, 1'b0, 8'h13, 1'b1); push(0, 1'b1, 8'h14, 1'b1);
        wait_done("t3_drain", 200);
        chk("t3_ready0_pulses", 32'(rdy_cnt[0]), 5);
        chk("t3_ready1_pulses", 32'(rdy_cnt[1]), 3);
        chk("t3_ready2_pulses", 32'(rdy_cnt[2]), 3);
        chk("t3_grant1_cycles", 32'(gcnt[1]), 14);

        // Hold timeout: req1 stalls mid-packet while req3 waits
        clear_counts();
        push(1, 1'b0, 8'h55, 1'b1);
        push(3, 1'b1, 8'h77, 1'b1);
        wait_done("t4_drain", 100);
        chk("t4_err_timeout", 32'(bus.err), 32'h2);
        chk("t4_grant1_cycles", 32'(gcnt[1]), 8);
        chk("t4_grant3_cycles", 32'(gcnt[3]), 4);
        bus.err_clr = 2'b10;
        @(posedge clk); #1;
        bus.err_clr = 2'b00;
        chk("t4_err_cleared", 32'(bus.err), 0);

        // Slave error on the first TX write of a 2-byte packet
        clear_counts();
        slverr_arm = 1'b1;
        push(2, 1'b0, 8'h61, 1'b1);
        push(2, 1'b1, 8'h62, 1'b1);
        wait_done("t5_drain", 100);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_err_slverr", 32'(bus.err), 32'h1);
        chk("t5_ready2_pulses", 32'(rdy_cnt[2]), 2);
        bus.err_clr = 2'b01;
        @(posedge clk); #1;
        bus.err_clr = 2'b00;
        chk("t5_err_cleared", 32'(bus.err), 0);

        // Reset during the TX write access phase
        clear_counts();
        push(3, 1'b1, 8'h99, 1'b0);
        n = 0;
        while (!(bus.apbm_psel && bus.apbm_penable && bus.apbm_pwrite) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL t6_reach_wr_a: write access phase never seen");
        end
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        #1;
        chk("t6_psel",    32'(bus.apbm_psel), 0);
        chk("t6_penable", 32'(bus.apbm_penable), 0);
        chk("t6_pwrite",  32'(bus.apbm_pwrite), 0);
        chk("t6_paddr",   32'(bus.apbm_paddr), 0);
        chk("t6_pwdata",  bus.apbm_pwdata, 0);
        chk("t6_grant",   32'(bus.grant), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_counts();
        push(0, 1'b1, 8'ha0, 1'b1);
        push(3, 1'b1, 8'ha3, 1'b1);
        wait_done("t6_drain", 100);
        chk("t6_ready0_pulses", 32'(rdy_cnt[0]), 1);
        chk("t6_ready3_pulses", 32'(rdy_cnt[3]), 1);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
